frame_sequencer: RTL and testbench

- Upstream stage of the exposition block: turns one external frame trigger into a burst of up to N_FRAMES_MAX exposures.
- For each frame, drives a launch pulse plus the matching delay/duration words from a small programmable table.
- Holds those words stable for the whole frame, because the exposition block reads them live.
- Spaces frames by a programmable period. The spacing is stretched automatically so one exposure always finishes before the next launch.

---
 rtl/frame_sequencer_if.sv | 40 ++++
 rtl/frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Purpose : bundles the trigger/control, table-config and per-frame output signals of frame_sequencer.
// Latency : none, signal bundle only.
// Backpress: none; all controls are strobes and the outputs are level/pulse signals.
// Ports   : master = controller/bench side (drives controls, reads frame outputs),
//           slave  = sequencer side (reads controls, drives Ex_launch/delay/duration/status).
interface frame_sequencer_if #(
  parameter int N_FRAMES_MAX = 8,
  parameter int CNT_W        = 33
);
  localparam int IDX_W = $clog2(N_FRAMES_MAX);

  logic             trig_in;
  logic             arm;
  logic             abort;
  logic [IDX_W:0]   n_frames;
  logic [CNT_W-1:0] period;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_duration;
  logic             Ex_launch;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] duration;
  logic [IDX_W-1:0] frame_idx;
  logic             busy;
  logic             done;
  logic             trig_err;

  modport master (
    output trig_in, arm, abort, n_frames, period,
    output cfg_we, cfg_addr, cfg_delay, cfg_duration,
    input  Ex_launch, delay, duration, frame_idx, busy, done, trig_err
  );

  modport slave (
    input  trig_in, arm, abort, n_frames, period,
    input  cfg_we, cfg_addr, cfg_delay, cfg_duration,
    output Ex_launch, delay, duration, frame_idx, busy, done, trig_err
  );
endinterface

// File: rtl/frame_sequencer.sv
// Purpose : turns one debounced external trigger into a burst of exposures, each with a launch
//           pulse and a delay/duration pair from a programmable table.
// Latency : Ex_launch first rises 2+DEBOUNCE edges after trig_in is first sampled high; frames
//           are spaced max(period, delay+duration+4) cycles.
// Backpress: none; controls are one-cycle strobes, table writes are dropped while busy.
// Ports   : clk_Seq/rst_Seq (sync, active-high) plus the slave side of frame_sequencer_if.
module frame_sequencer #(
  parameter int N_FRAMES_MAX = 8,
  parameter int CNT_W        = 33,
  parameter int DEBOUNCE     = 4,
  parameter int LAUNCH_W     = 2
) (
  input logic              clk_Seq,
  input logic              rst_Seq,
  frame_sequencer_if.slave sq
);
  localparam int IDX_W = $clog2(N_FRAMES_MAX);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  // Two guard bits: delay + duration + 4 can exceed CNT_W+1 bits when both words are near max.
  localparam int PW    = CNT_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             trig_acc_q;
  logic [CNT_W-1:0] tbl_del_q [N_FRAMES_MAX];
  logic [CNT_W-1:0] tbl_dur_q [N_FRAMES_MAX];
  logic [IDX_W:0]   nfr_q, nfr_d, n_clamped;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] delay_q, delay_d, dur_q, dur_d;
  logic             launch_q, launch_d;
  logic             err_q, err_d;
  logic [PW-1:0]    need, peff;
  logic             last_frame;

  // Debounce: saturate at DEBOUNCE, clear on any low synchronized sample.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (!sync2_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_W'(DEBOUNCE)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    n_clamped = sq.n_frames;
    if (sq.n_frames == '0) begin
      n_clamped = (IDX_W+1)'(1);
    end else if (sq.n_frames > (IDX_W+1)'(N_FRAMES_MAX)) begin
      n_clamped = (IDX_W+1)'(N_FRAMES_MAX);
    end
  end

  assign need       = {2'b00, delay_q} + {2'b00, dur_q} + PW'(4);
  assign peff       = ({2'b00, period_q} > need) ? {2'b00, period_q} : need;
  assign last_frame = ({1'b0, idx_q} == (nfr_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    nfr_d    = nfr_q;
    period_d = period_q;
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    delay_d  = delay_q;
    dur_d    = dur_q;
    err_d    = 1'b0;
    launch_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A trigger landing in IDLE (even together with arm) is dropped silently.
        if (sq.arm) begin
          state_d  = S_ARMED;
          nfr_d    = n_clamped;
          period_d = sq.period;
        end
      end
      S_ARMED: begin
        if (trig_acc_q) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
        end
      end
      S_LAUNCH: begin
        err_d   = trig_acc_q;
        state_d = S_WAIT;
        pcnt_d  = pcnt_q + 1'b1;
      end
      S_WAIT: begin
        err_d  = trig_acc_q;
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q >= peff) begin
          if (last_frame) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LAUNCH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        err_d   = trig_acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Words and the period counter load on the same edge the launch rises, so the
    // exposition block sees matching values for the whole frame. Counter value k means
    // k-1 cycles have elapsed since the rise.
    if (state_d == S_LAUNCH) begin
      pcnt_d  = PW'(1);
      delay_d = tbl_del_q[idx_d];
      dur_d   = tbl_dur_q[idx_d];
    end

    if (sq.abort) begin
      state_d  = S_IDLE;
      err_d    = 1'b0;
      nfr_d    = nfr_q;
      period_d = period_q;
      pcnt_d   = pcnt_q;
      idx_d    = idx_q;
      delay_d  = delay_q;
      dur_d    = dur_q;
    end

    launch_d = ((state_d == S_LAUNCH) || (state_d == S_WAIT)) && (pcnt_d <= PW'(LAUNCH_W));
  end

  always_ff @(posedge clk_Seq) begin
    if (rst_Seq) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      trig_acc_q <= 1'b0;
      state_q    <= S_IDLE;
      nfr_q      <= '0;
      period_q   <= '0;
      pcnt_q     <= '0;
      idx_q      <= '0;
      delay_q    <= '0;
      dur_q      <= '0;
      launch_q   <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_FRAMES_MAX; i++) begin
        tbl_del_q[i] <= '0;
        tbl_dur_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sq.trig_in;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      trig_acc_q <= (db_cnt_d == DB_W'(DEBOUNCE)) && (db_cnt_q != DB_W'(DEBOUNCE));
      state_q    <= state_d;
      nfr_q      <= nfr_d;
      period_q   <= period_d;
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      delay_q    <= delay_d;
      dur_q      <= dur_d;
      launch_q   <= launch_d;
      err_q      <= err_d;
      if ((state_q == S_IDLE) && sq.cfg_we) begin
        tbl_del_q[sq.cfg_addr] <= sq.cfg_delay;
        tbl_dur_q[sq.cfg_addr] <= sq.cfg_duration;
      end
    end
  end

  assign sq.Ex_launch = launch_q;
  assign sq.delay     = delay_q;
  assign sq.duration  = dur_q;
  assign sq.frame_idx = idx_q;
  assign sq.busy      = (state_q != S_IDLE);
  assign sq.done      = (state_q == S_DONE);
  assign sq.trig_err  = err_q;
endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  localparam int N     = 8;
  localparam int CNT_W = 33;
  localparam int DEB   = 4;
  localparam int LW    = 2;
  localparam int IDX_W = 3;

  logic clk_Seq = 1'b0;
  logic rst_Seq = 1'b1;
  always #5 clk_Seq = ~clk_Seq;

  frame_sequencer_if #(.N_FRAMES_MAX(N), .CNT_W(CNT_W)) sq ();

  frame_sequencer #(.N_FRAMES_MAX(N), .CNT_W(CNT_W), .DEBOUNCE(DEB), .LAUNCH_W(LW)) dut (
    .clk_Seq(clk_Seq),
    .rst_Seq(rst_Seq),
    .sq     (sq)
  );

  int cyc = 0;
  always @(posedge clk_Seq) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference copy of the table, updated only by writes issued while idle.
  logic [CNT_W-1:0] m_del [N];
  logic [CNT_W-1:0] m_dur [N];

  function automatic int n_eff(input int n);
    if (n == 0) return 1;
    if (n > N) return N;
    return n;
  endfunction

  function automatic longint peff_of(input int f, input int per);
    longint s;
    s = longint'(m_del[f]) + longint'(m_dur[f]) + 4;
    return (longint'(per) > s) ? longint'(per) : s;
  endfunction

  function automatic longint model_total(input int n, input int per);
    longint t;
    t = 0;
    for (int f = 0; f < n_eff(n); f++) t += peff_of(f, per);
    return t;
  endfunction

  // Expected outputs r cycles after the first launch rise of a burst.
  task automatic model_at(input int r, input int n, input int per,
                          output logic el, output logic eb, output logic edn,
                          output logic [CNT_W-1:0] ed, output logic [CNT_W-1:0] eu,
                          output logic [IDX_W-1:0] ei);
    longint start, pe;
    int ne;
    bit found;
    ne = n_eff(n);
    start = 0; found = 0;
    el = 0; eb = 0; edn = 0;
    ei = IDX_W'(ne - 1); ed = m_del[ne-1]; eu = m_dur[ne-1];
    for (int f = 0; f < ne; f++) begin
      pe = peff_of(f, per);
      if (!found && longint'(r) < start + pe) begin
        found = 1;
        el = (longint'(r) - start) < LW;
        eb = 1; ed = m_del[f]; eu = m_dur[f]; ei = IDX_W'(f);
      end
      if (!found) start += pe;
    end
    if (!found && longint'(r) == start) begin
      eb = 1; edn = 1;
    end
  endtask

  task automatic cfg_write(input int a, input int d, input int u);
    @(negedge clk_Seq);
    sq.cfg_we = 1'b1; sq.cfg_addr = IDX_W'(a);
    sq.cfg_delay = CNT_W'(d); sq.cfg_duration = CNT_W'(u);
    @(negedge clk_Seq);
    sq.cfg_we = 1'b0;
    m_del[a] = CNT_W'(d); m_dur[a] = CNT_W'(u);
  endtask

  // Arms a burst and raises the trigger; returns the edge at which the first launch must rise.
  task automatic do_arm_trig(input int n, input int per, output int t0);
    @(negedge clk_Seq);
    sq.arm = 1'b1; sq.n_frames = (IDX_W+1)'(n); sq.period = CNT_W'(per);
    @(negedge clk_Seq);
    sq.arm = 1'b0; sq.trig_in = 1'b1;
    t0 = cyc + 1 + 2 + DEB;
  endtask

  task automatic test_reset();
    rst_Seq = 1'b1;
    repeat (3) @(negedge clk_Seq);
    chk_cnt++;
    if ({sq.Ex_launch, sq.busy, sq.done, sq.trig_err} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {sq.Ex_launch, sq.busy, sq.done, sq.trig_err});
    else pass_cnt++;
    chk_cnt++;
    if ({sq.delay, sq.duration} !== '0)
      $display("FAIL reset_words got %0d/%0d want 0/0", sq.delay, sq.duration);
    else pass_cnt++;
    chk_cnt++;
    if (sq.frame_idx !== '0) $display("FAIL reset_idx got %0d want 0", sq.frame_idx);
    else pass_cnt++;
    rst_Seq = 1'b0;
    for (int i = 0; i < N; i++) begin m_del[i] = '0; m_dur[i] = '0; end
  endtask

  // Full burst against the model; disturb adds a busy-time table write and a second trigger.
  task automatic test_burst(input string name, input int n, input int per, input bit disturb);
    int t0, last, r, errs;
    logic el, eb, edn;
    logic [CNT_W-1:0] ed, eu;
    logic [IDX_W-1:0] ei;
    errs = 0;
    do_arm_trig(n, per, t0);
    last = t0 + int'(model_total(n, per)) + 2;
    while (cyc < last) begin
      @(negedge clk_Seq);
      r = cyc - t0;
      if (r == 0) sq.trig_in = 1'b0;
      if (disturb) begin
        if (r == 30) begin
          sq.cfg_we = 1'b1; sq.cfg_addr = IDX_W'(1);
          sq.cfg_delay = CNT_W'(999); sq.cfg_duration = CNT_W'(999);
        end
        if (r == 31) sq.cfg_we = 1'b0;
        if (r == 40) sq.trig_in = 1'b1;
        if (r == 50) sq.trig_in = 1'b0;
      end
      if (sq.trig_err === 1'b1) errs++;
      if (r < 0) begin
        chk_cnt++;
        if ({sq.Ex_launch, sq.busy} !== 2'b01)
          $display("FAIL %s armed r=%0d launch/busy got %b want 01", name, r, {sq.Ex_launch, sq.busy});
        else pass_cnt++;
      end else begin
        model_at(r, n, per, el, eb, edn, ed, eu, ei);
        chk_cnt++;
        if (sq.Ex_launch !== el)
          $display("FAIL %s launch r=%0d got %b want %b", name, r, sq.Ex_launch, el);
        else pass_cnt++;
        chk_cnt++;
        if ({sq.busy, sq.done} !== {eb, edn})
          $display("FAIL %s busy_done r=%0d got %b want %b", name, r, {sq.busy, sq.done}, {eb, edn});
        else pass_cnt++;
        chk_cnt++;
        if ({sq.delay, sq.duration, sq.frame_idx} !== {ed, eu, ei})
          $display("FAIL %s words r=%0d got %0d/%0d/%0d want %0d/%0d/%0d", name, r,
                   sq.delay, sq.duration, sq.frame_idx, ed, eu, ei);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (errs !== (disturb ? 1 : 0))
      $display("FAIL %s trig_err_pulses got %0d want %0d", name, errs, disturb ? 1 : 0);
    else pass_cnt++;
  endtask

  task automatic test_debounce();
    int launches, c2, k;
    @(negedge clk_Seq);
    sq.arm = 1'b1; sq.n_frames = 4'd1; sq.period = CNT_W'(20);
    @(negedge clk_Seq);
    sq.arm = 1'b0; sq.trig_in = 1'b1;
    repeat (3) @(negedge clk_Seq);
    sq.trig_in = 1'b0;
    launches = 0;
    repeat (15) begin
      @(negedge clk_Seq);
      if (sq.Ex_launch === 1'b1) launches++;
    end
    chk_cnt++;
    if (launches !== 0) $display("FAIL debounce_short launches got %0d want 0", launches);
    else pass_cnt++;
    chk_cnt++;
    if (sq.busy !== 1'b1) $display("FAIL debounce_short busy got %b want 1", sq.busy);
    else pass_cnt++;
    sq.trig_in = 1'b1;
    c2 = cyc;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_Seq);
      if (i == 4) sq.trig_in = 1'b0;
      if (i == 6) begin
        chk_cnt++;
        if (sq.Ex_launch !== 1'b0) $display("FAIL debounce_early launch at k+5 got %b want 0", sq.Ex_launch);
        else pass_cnt++;
      end
      if (i == 7) begin
        chk_cnt++;
        if (sq.Ex_launch !== 1'b1 || cyc != c2 + 7)
          $display("FAIL debounce_launch at k+6 got %b want 1", sq.Ex_launch);
        else pass_cnt++;
      end
    end
    k = 0;
    while (sq.busy === 1'b1 && k < 300) begin @(negedge clk_Seq); k++; end
    chk_cnt++;
    if (sq.busy !== 1'b0) $display("FAIL debounce_finish busy got %b want 0", sq.busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int t0, p0, dones, launches, k;
    p0 = int'(model_total(1, 100));
    do_arm_trig(3, 100, t0);
    while (cyc < t0 + p0 + 20) begin
      @(negedge clk_Seq);
      if (cyc == t0) sq.trig_in = 1'b0;
    end
    sq.abort = 1'b1;
    @(negedge clk_Seq);
    sq.abort = 1'b0;
    chk_cnt++;
    if ({sq.busy, sq.Ex_launch, sq.done} !== 3'b000)
      $display("FAIL abort_flags got %b want 000", {sq.busy, sq.Ex_launch, sq.done});
    else pass_cnt++;
    chk_cnt++;
    if ({sq.delay, sq.duration} !== {m_del[1], m_dur[1]})
      $display("FAIL abort_hold got %0d/%0d want %0d/%0d", sq.delay, sq.duration, m_del[1], m_dur[1]);
    else pass_cnt++;
    dones = 0; launches = 0;
    repeat (300) begin
      @(negedge clk_Seq);
      if (sq.done === 1'b1) dones++;
      if (sq.Ex_launch === 1'b1) launches++;
    end
    chk_cnt++;
    if (dones + launches !== 0)
      $display("FAIL abort_quiet done+launch pulses got %0d want 0", dones + launches);
    else pass_cnt++;
    do_arm_trig(3, 100, t0);
    while (cyc < t0) @(negedge clk_Seq);
    sq.trig_in = 1'b0;
    chk_cnt++;
    if ({sq.Ex_launch, sq.frame_idx, sq.delay} !== {1'b1, IDX_W'(0), m_del[0]})
      $display("FAIL abort_restart got %b/%0d/%0d want 1/0/%0d", sq.Ex_launch, sq.frame_idx, sq.delay, m_del[0]);
    else pass_cnt++;
    k = 0;
    while (sq.busy === 1'b1 && k < 600) begin @(negedge clk_Seq); k++; end
    chk_cnt++;
    if (sq.busy !== 1'b0) $display("FAIL abort_restart_finish busy got %b want 0", sq.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int t0, k;
    do_arm_trig(3, 100, t0);
    while (cyc < t0) @(negedge clk_Seq);
    rst_Seq = 1'b1; sq.trig_in = 1'b0;
    @(negedge clk_Seq);
    chk_cnt++;
    if ({sq.Ex_launch, sq.busy, sq.done, sq.trig_err, sq.frame_idx, sq.delay, sq.duration} !== '0)
      $display("FAIL reset_mid outputs got %b/%b/%0d/%0d want all 0", sq.Ex_launch, sq.busy, sq.delay, sq.duration);
    else pass_cnt++;
    rst_Seq = 1'b0;
    for (int i = 0; i < N; i++) begin m_del[i] = '0; m_dur[i] = '0; end
    do_arm_trig(2, 30, t0);
    while (cyc < t0) @(negedge clk_Seq);
    sq.trig_in = 1'b0;
    chk_cnt++;
    if ({sq.Ex_launch, sq.delay, sq.duration} !== {1'b1, CNT_W'(0), CNT_W'(0)})
      $display("FAIL reset_mid_table got %b/%0d/%0d want 1/0/0", sq.Ex_launch, sq.delay, sq.duration);
    else pass_cnt++;
    k = 0;
    while (sq.busy === 1'b1 && k < 300) begin @(negedge clk_Seq); k++; end
    chk_cnt++;
    if (sq.busy !== 1'b0) $display("FAIL reset_mid_finish busy got %b want 0", sq.busy);
    else pass_cnt++;
  endtask

  initial begin
    sq.trig_in = 1'b0; sq.arm = 1'b0; sq.abort = 1'b0;
    sq.n_frames = '0; sq.period = '0;
    sq.cfg_we = 1'b0; sq.cfg_addr = '0; sq.cfg_delay = '0; sq.cfg_duration = '0;
    test_reset();
    cfg_write(0, 10, 20);
    cfg_write(1, 30, 5);
    cfg_write(2, 7, 7);
    test_burst("table3", 3, 100, 1'b0);
    cfg_write(0, 50, 60);
    test_burst("stretch", 2, 10, 1'b0);
    cfg_write(0, 10, 20);
    test_burst("busy_ignore", 3, 100, 1'b1);
    test_debounce();
    test_abort();
    test_reset_mid();
    for (int b = 0; b < 5; b++) begin
      for (int e = 0; e < N; e++) cfg_write(e, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)));
      test_burst($sformatf("random%0d", b), int'($urandom_range(0, 10)), int'($urandom_range(0, 150)), 1'b0);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end
endmodule
